// File: rtl/lattice_bram_arbiter_pkg.sv
// Shared types and configuration for the lattice BRAM arbiter slice:
// lattice word layout, direction indices and read-owner tags.
package lbm_pkg;

  localparam int BRAM_DEPTH   = 31570;
  localparam int ADDR_W       = $clog2(BRAM_DEPTH);
  localparam int READ_LATENCY = 2;
  localparam int MAX_WAIT     = 4;

  // One byte per lattice direction, indexed by the constants below.
  typedef logic [8:0][7:0] lattice_word_t;

  localparam int CENTER = 0;
  localparam int N      = 1;
  localparam int NE     = 2;
  localparam int E      = 3;
  localparam int SE     = 4;
  localparam int S      = 5;
  localparam int SW     = 6;
  localparam int W      = 7;
  localparam int NW     = 8;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_SIM,
    OWN_DISP
  } owner_t;

endpackage

// File: rtl/lattice_bram_arbiter_if.sv
// Client-side bus of the lattice BRAM arbiter: the read/write sim port
// and the read-only display port.
interface lattice_bram_arbiter_if;
  import lbm_pkg::*;

  logic                sim_req_in;
  logic                sim_we_in;
  logic [ADDR_W-1:0]   sim_addr_in;
  lattice_word_t       sim_data_in;
  logic                sim_gnt_out;
  logic                sim_rvalid_out;
  lattice_word_t       sim_rdata_out;

  logic                disp_req_in;
  logic [ADDR_W-1:0]   disp_addr_in;
  logic                disp_gnt_out;
  logic                disp_rvalid_out;
  lattice_word_t       disp_rdata_out;

  modport master (
    output sim_req_in, sim_we_in, sim_addr_in, sim_data_in,
    input  sim_gnt_out, sim_rvalid_out, sim_rdata_out,
    output disp_req_in, disp_addr_in,
    input  disp_gnt_out, disp_rvalid_out, disp_rdata_out
  );

  modport slave (
    input  sim_req_in, sim_we_in, sim_addr_in, sim_data_in,
    output sim_gnt_out, sim_rvalid_out, sim_rdata_out,
    input  disp_req_in, disp_addr_in,
    output disp_gnt_out, disp_rvalid_out, disp_rdata_out
  );

endinterface

// File: rtl/lattice_bram_arbiter_read_tag_pipe.sv
// Shift register carrying the owner and out-of-range flag of each accepted
// read alongside the BRAM latency, so returned data can be routed.
module read_tag_pipe
  import lbm_pkg::*;
#(
  parameter int DEPTH = READ_LATENCY + 1
) (
  input  logic   clk_in,
  input  logic   rst_n_in,
  input  owner_t owner_in,
  input  logic   oor_in,
  output owner_t owner_out,
  output logic   oor_out
);

  owner_t owner_q [DEPTH];
  logic   oor_q   [DEPTH];

  // NOTE: this array is a pipeline, not storage; it must clear so reads in
  // flight at reset never emerge as rvalid afterwards.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        owner_q[i] <= OWN_NONE;
        oor_q[i]   <= 1'b0;
      end
    end else begin
      owner_q[0] <= owner_in;
      oor_q[0]   <= oor_in;
      for (int i = 1; i < DEPTH; i++) begin
        owner_q[i] <= owner_q[i-1];
        oor_q[i]   <= oor_q[i-1];
      end
    end
  end

  assign owner_out = owner_q[DEPTH-1];
  assign oor_out   = oor_q[DEPTH-1];

endmodule

// File: rtl/lattice_bram_arbiter.sv
// Arbitrates the single-port lattice BRAM between the sim engine (read/write)
// and the display reader (read-only); display-first with a sim starvation bound.
module lattice_bram_arbiter
  import lbm_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  lattice_bram_arbiter_if.slave bus,
  output logic                 bram_en_out,
  output logic                 bram_we_out,
  output logic [ADDR_W-1:0]    bram_addr_out,
  output lattice_word_t        bram_din_out,
  input  lattice_word_t        bram_dout_in
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic              sim_gnt, disp_gnt, wait_full;
  logic              acc_valid, acc_we, acc_oor;
  logic [ADDR_W-1:0] acc_addr;
  owner_t            push_owner, pop_owner;
  logic              pop_oor;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    wait_full  = (wait_cnt == WAIT_W'(MAX_WAIT));
    sim_gnt    = 1'b0;
    disp_gnt   = 1'b0;
    push_owner = OWN_NONE;
    if (rst_n_in) begin
      sim_gnt  = bus.sim_req_in && (!bus.disp_req_in || wait_full);
      disp_gnt = bus.disp_req_in && !sim_gnt;
    end
    acc_valid = sim_gnt || disp_gnt;
    acc_addr  = sim_gnt ? bus.sim_addr_in : bus.disp_addr_in;
    acc_we    = sim_gnt && bus.sim_we_in;
    acc_oor   = (acc_addr >= ADDR_W'(BRAM_DEPTH));
    if (acc_valid && !acc_we) push_owner = sim_gnt ? OWN_SIM : OWN_DISP;
  end

  assign bus.sim_gnt_out  = sim_gnt;
  assign bus.disp_gnt_out = disp_gnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wait_cnt <= '0;
    end else if (sim_gnt) begin
      wait_cnt <= '0;
    end else if (bus.sim_req_in && !wait_full) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // Out-of-range accesses never reach the BRAM; a read still returns zero.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bram_en_out   <= 1'b0;
      bram_we_out   <= 1'b0;
      bram_addr_out <= '0;
      bram_din_out  <= '0;
    end else begin
      bram_en_out <= acc_valid && !acc_oor;
      bram_we_out <= acc_we && !acc_oor;
      if (acc_valid) bram_addr_out <= acc_addr;
      if (sim_gnt)   bram_din_out  <= bus.sim_data_in;
    end
  end

  read_tag_pipe #(.DEPTH(READ_LATENCY + 1)) u_tag_pipe (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .owner_in  (push_owner),
    .oor_in    (acc_oor),
    .owner_out (pop_owner),
    .oor_out   (pop_oor)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bus.sim_rvalid_out  <= 1'b0;
      bus.sim_rdata_out   <= '0;
      bus.disp_rvalid_out <= 1'b0;
      bus.disp_rdata_out  <= '0;
    end else begin
      bus.sim_rvalid_out  <= (pop_owner == OWN_SIM);
      bus.disp_rvalid_out <= (pop_owner == OWN_DISP);
      if (pop_owner == OWN_SIM)  bus.sim_rdata_out  <= pop_oor ? '0 : bram_dout_in;
      if (pop_owner == OWN_DISP) bus.disp_rdata_out <= pop_oor ? '0 : bram_dout_in;
    end
  end

endmodule

// File: tb/tb_lattice_bram_arbiter.sv
// Bench for lattice_bram_arbiter: BRAM model, transaction-level reference
// model compared every cycle, plus directed literal expectations.
module tb_lattice_bram_arbiter;
  import lbm_pkg::*;

  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;
  always #5 clk_in = ~clk_in;

  lattice_bram_arbiter_if bus();

  logic              bram_en, bram_we;
  logic [ADDR_W-1:0] bram_addr;
  lattice_word_t     bram_din, bram_dout;

  lattice_bram_arbiter dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .bus           (bus),
    .bram_en_out   (bram_en),
    .bram_we_out   (bram_we),
    .bram_addr_out (bram_addr),
    .bram_din_out  (bram_din),
    .bram_dout_in  (bram_dout)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic lattice_word_t pat(input int a);
    lattice_word_t w;
    for (int d = 0; d < 9; d++) w[d] = 8'(a * 9 + d);
    return w;
  endfunction

  // BRAM: address sampled at the edge, dout valid READ_LATENCY cycles later.
  lattice_word_t mem     [BRAM_DEPTH];
  lattice_word_t ref_mem [BRAM_DEPTH];
  lattice_word_t r1 = '0, r2 = '0;

  initial begin
    for (int i = 0; i < BRAM_DEPTH; i++) begin
      mem[i]     = pat(i);
      ref_mem[i] = pat(i);
    end
  end

  always @(posedge clk_in) begin
    r2 <= r1;
    if (bram_en && bram_addr < ADDR_W'(BRAM_DEPTH)) begin
      if (bram_we) mem[bram_addr] <= bram_din;
      else         r1 <= mem[bram_addr];
    end
  end
  assign bram_dout = r2;

  // Reference model: accepted accesses become queued read returns due 4 cycles later.
  typedef struct {
    int            due;
    bit            to_sim;
    lattice_word_t data;
  } rd_t;

  rd_t               pend[$];
  int                cyc   = 0;
  int                mwait = 0;
  bit                e_en = 0, e_we = 0, e_srv = 0, e_drv = 0;
  logic [ADDR_W-1:0] e_addr = '0;
  lattice_word_t     e_din = '0, e_srd = '0, e_drd = '0;

  function automatic bit exp_sim_gnt();
    return rst_n_in && bus.sim_req_in && (!bus.disp_req_in || mwait == MAX_WAIT);
  endfunction

  function automatic bit exp_disp_gnt();
    return rst_n_in && bus.disp_req_in && !exp_sim_gnt();
  endfunction

  always @(posedge clk_in or negedge rst_n_in) begin : model
    bit                sg, dg, oor;
    logic [ADDR_W-1:0] a;
    lattice_word_t     rd;
    if (!rst_n_in) begin
      mwait = 0;
      e_en = 0; e_we = 0; e_srv = 0; e_drv = 0;
      e_srd = '0; e_drd = '0;
      pend.delete();
    end else begin
      sg  = exp_sim_gnt();
      dg  = exp_disp_gnt();
      a   = sg ? bus.sim_addr_in : bus.disp_addr_in;
      oor = (int'(a) >= BRAM_DEPTH);
      e_en = (sg || dg) && !oor;
      e_we = sg && bus.sim_we_in && !oor;
      if (e_en) e_addr = a;
      if (e_we) e_din  = bus.sim_data_in;
      if ((sg && !bus.sim_we_in) || dg) begin
        rd = oor ? lattice_word_t'(0) : ref_mem[a];
        pend.push_back(rd_t'{due: cyc + 4, to_sim: sg, data: rd});
      end
      if (e_we) ref_mem[a] = bus.sim_data_in;
      if (sg) mwait = 0;
      else if (bus.sim_req_in && mwait < MAX_WAIT) mwait++;
      cyc++;
      e_srv = 0;
      e_drv = 0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        if (pend[0].to_sim) begin e_srv = 1; e_srd = pend[0].data; end
        else                begin e_drv = 1; e_drd = pend[0].data; end
        void'(pend.pop_front());
      end
    end
  end

  int n_srv = 0, n_drv = 0;

  always @(negedge clk_in) begin
    check("sim_gnt", bus.sim_gnt_out, exp_sim_gnt());
    check("disp_gnt", bus.disp_gnt_out, exp_disp_gnt());
    check("bram_en", bram_en, e_en);
    check("bram_we", bram_we, e_we);
    if (e_en) check("bram_addr", bram_addr, e_addr);
    if (e_we) check("bram_din", bram_din, e_din);
    check("sim_rvalid", bus.sim_rvalid_out, e_srv);
    check("disp_rvalid", bus.disp_rvalid_out, e_drv);
    check("sim_rdata", bus.sim_rdata_out, e_srd);
    check("disp_rdata", bus.disp_rdata_out, e_drd);
    if (bus.sim_rvalid_out)  n_srv++;
    if (bus.disp_rvalid_out) n_drv++;
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    bus.sim_req_in  = 1'b0;
    bus.sim_we_in   = 1'b0;
    bus.disp_req_in = 1'b0;
  endtask

  task automatic sim_acc(input bit we, input int a, input lattice_word_t d);
    bus.sim_req_in  = 1'b1;
    bus.sim_we_in   = we;
    bus.sim_addr_in = ADDR_W'(a);
    bus.sim_data_in = d;
  endtask

  task automatic disp_acc(input int a);
    bus.disp_req_in  = 1'b1;
    bus.disp_addr_in = ADDR_W'(a);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sim_gnt"}, bus.sim_gnt_out, 1'b0);
    check({tag, "_disp_gnt"}, bus.disp_gnt_out, 1'b0);
    check({tag, "_rvalid"}, {bus.sim_rvalid_out, bus.disp_rvalid_out}, 2'b00);
    check({tag, "_en_we"}, {bram_en, bram_we}, 2'b00);
    check({tag, "_addr"}, bram_addr, '0);
    check({tag, "_din"}, bram_din, '0);
    check({tag, "_sim_rdata"}, bus.sim_rdata_out, '0);
    check({tag, "_disp_rdata"}, bus.disp_rdata_out, '0);
  endtask

  int s0, d0;
  lattice_word_t w0a, wff;

  initial begin
    w0a = {9{8'h0A}};
    wff = {9{8'hFF}};
    idle();
    bus.sim_addr_in  = '0;
    bus.sim_data_in  = '0;
    bus.disp_addr_in = '0;

    // Reset state, with a request pending that must not be granted.
    repeat (3) step();
    sim_acc(1'b0, 3, '0);
    #1;
    check_all_zero("reset");
    idle();
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // Sim write of 0x0A to address 5, then read it back.
    step();
    sim_acc(1'b1, 5, w0a);
    #1;
    check("wr_gnt", bus.sim_gnt_out, 1'b1);
    step();
    idle();
    check("wr_bram", {bram_en, bram_we, 17'(bram_addr)}, {2'b11, 17'd5});
    sim_acc(1'b0, 5, '0);
    #1;
    check("rd_gnt", bus.sim_gnt_out, 1'b1);
    step();
    idle();
    for (int k = 1; k <= 4; k++) begin
      check("rd_latency", bus.sim_rvalid_out, (k == 4));
      if (k < 4) step();
    end
    check("rd_data", bus.sim_rdata_out, w0a);
    check("rd_no_disp", bus.disp_rvalid_out, 1'b0);
    step();
    check("rd_pulse_end", bus.sim_rvalid_out, 1'b0);

    // Both requesters held: display x4, sim on the 5th, repeating.
    sim_acc(1'b0, 10, '0);
    disp_acc(20);
    for (int i = 0; i < 12; i++) begin
      #1;
      check("prio_sim", bus.sim_gnt_out, (i % 5 == 4));
      check("prio_disp", bus.disp_gnt_out, (i % 5 != 4));
      step();
    end
    idle();
    repeat (6) step();

    // Alternating single-requester reads, addresses 0..7.
    s0 = n_srv;
    d0 = n_drv;
    for (int i = 0; i < 8; i++) begin
      idle();
      if (i % 2 == 0) sim_acc(1'b0, i, '0);
      else            disp_acc(i);
      step();
    end
    idle();
    repeat (6) step();
    check("alt_sim_count", n_srv - s0, 4);
    check("alt_disp_count", n_drv - d0, 4);
    check("alt_sim_last", bus.sim_rdata_out, pat(6));
    check("alt_disp_last", bus.disp_rdata_out, pat(7));

    // Out-of-range display read and sim write.
    disp_acc(BRAM_DEPTH);
    step();
    idle();
    check("oor_rd_en", bram_en, 1'b0);
    repeat (3) step();
    check("oor_rd_rvalid", bus.disp_rvalid_out, 1'b1);
    check("oor_rd_data", bus.disp_rdata_out, '0);
    sim_acc(1'b1, BRAM_DEPTH, wff);
    step();
    idle();
    check("oor_wr_en", {bram_en, bram_we}, 2'b00);
    repeat (5) step();
    sim_acc(1'b0, 5, '0);
    step();
    idle();
    repeat (3) step();
    check("oor_wr_intact", bus.sim_rdata_out, w0a);
    step();

    // Reset with three reads in flight.
    for (int i = 1; i <= 3; i++) begin
      sim_acc(1'b0, i, '0);
      step();
    end
    rst_n_in = 1'b0;
    #1;
    check_all_zero("midrst");
    idle();
    repeat (2) step();
    @(negedge clk_in);
    rst_n_in = 1'b1;
    s0 = n_srv;
    step();
    sim_acc(1'b0, 7, '0);
    #1;
    check("post_rst_gnt", bus.sim_gnt_out, 1'b1);
    step();
    idle();
    repeat (3) step();
    check("post_rst_rvalid", bus.sim_rvalid_out, 1'b1);
    check("post_rst_data", bus.sim_rdata_out, pat(7));
    repeat (4) step();
    check("post_rst_count", n_srv - s0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
